// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch FIFO, req/ack memory port and redirect flush.
// Optional macro IF_BYPASS_EN: forward an ack straight to the id_* outputs when the FIFO is empty.
module if_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_next_pc
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic              mem_req_reg, mem_req_next;

    logic push;
    logic pop;
    logic store_en;
    logic fifo_pop;
    logic fifo_valid;
    logic bypass_hit;

    logic [DATA_W-1:0] slot_inst [DEPTH];
    logic [ADDR_W-1:0] slot_pc   [DEPTH];

    assign fifo_valid = (count_reg != '0);
    assign push       = mem_req_reg && mem_ack && !redirect_valid;

`ifdef IF_BYPASS_EN
    assign bypass_hit = push && !fifo_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign id_valid = fifo_valid || bypass_hit;
    assign pop      = id_valid && id_ready && !redirect_valid;
    // A bypassed word that decode takes immediately never occupies a slot.
    assign store_en = push && !(bypass_hit && id_ready);
    assign fifo_pop = pop && fifo_valid;

    always_comb begin
        count_next    = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        fetch_pc_next = fetch_pc_reg;
        mem_req_next  = mem_req_reg;
        if (redirect_valid) begin
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            fetch_pc_next = redirect_pc & WORD_MASK;
            mem_req_next  = 1'b1;
        end else begin
            count_next = count_reg + CNT_W'(store_en) - CNT_W'(fifo_pop);
            if (store_en) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            if (push) begin
                fetch_pc_next = fetch_pc_reg + WORD_STEP;
            end
            mem_req_next = (count_next < FULL_COUNT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            fetch_pc_reg <= RESET_PC;
            mem_req_reg  <= 1'b0;
        end else begin
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            fetch_pc_reg <= fetch_pc_next;
            mem_req_reg  <= mem_req_next;
        end
    end

    // Slots need no reset: they are only observed while count_reg says they hold data.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [DATA_W-1:0] inst_reg;
            logic [ADDR_W-1:0] pc_reg;

            always_ff @(posedge clk) begin
                if (store_en && (wr_ptr_reg == PTR_W'(gi))) begin
                    inst_reg <= mem_rdata;
                    pc_reg   <= fetch_pc_reg;
                end
            end

            assign slot_inst[gi] = inst_reg;
            assign slot_pc[gi]   = pc_reg;
        end
    endgenerate

    always_comb begin
        id_inst = '0;
        id_pc   = '0;
        if (fifo_valid) begin
            id_inst = slot_inst[rd_ptr_reg];
            id_pc   = slot_pc[rd_ptr_reg];
        end else if (bypass_hit) begin
            id_inst = mem_rdata;
            id_pc   = fetch_pc_reg;
        end
    end

    assign id_next_pc = id_pc + WORD_STEP;
    assign mem_req    = mem_req_reg;
    assign mem_addr   = fetch_pc_reg;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue: a memory model pushes expected words, a monitor checks pops.
// Honours IF_BYPASS_EN the same way the design does.
module tb_if_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_next_pc;

    int          checks = 0;
    int          failures = 0;
    int          beat_count = 0;
    int          ack_mode = 0;     // 0 never, 1 always, 2 random
    logic [31:0] rdata_xor = 32'hA5A5A5A5;
    logic [31:0] exp_fetch_pc = 32'h0;
    logic        rst_prev = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t exp_q[$];

    if_prefetch_queue #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .id_next_pc    (id_next_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory: answers 2 time units after the edge so stimulus settles first.
    always @(posedge clk) begin
        #2;
        case (ack_mode)
            1:       mem_ack = 1'b1;
            2:       mem_ack = ($urandom_range(0, 1) == 1);
            default: mem_ack = 1'b0;
        endcase
        mem_rdata = mem_addr ^ rdata_xor;
    end

    logic b_comb;
    logic beat;
    logic exp_valid;
    exp_t e;

    // Monitor: predicts pushes from its own fetch-pc model, checks every pop against the queue.
    always @(negedge clk) begin
        if (rst_prev) begin
            b_comb = mem_req && mem_ack && !redirect_valid;
            beat   = rst && b_comb;
            chk("mem_addr_model", mem_addr, exp_fetch_pc);
            chk("mem_req_vs_fill", 32'(mem_req), (exp_q.size() < DEPTH) ? 32'd1 : 32'd0);
`ifdef IF_BYPASS_EN
            exp_valid = (exp_q.size() != 0) || b_comb;
`else
            exp_valid = (exp_q.size() != 0);
`endif
            chk("id_valid_vs_fill", 32'(id_valid), 32'(exp_valid));
            if (beat) begin
                exp_q.push_back('{pc: exp_fetch_pc, inst: exp_fetch_pc ^ rdata_xor});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
                beat_count++;
                chk("fill_bound", (exp_q.size() <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
            end
            if (rst && id_valid && id_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop_pc", id_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    $display("POP pc=%h inst=%h next=%h", id_pc, id_inst, id_next_pc);
                    chk("pop_pc", id_pc, e.pc);
                    chk("pop_inst", id_inst, e.inst);
                    chk("pop_next_pc", id_next_pc, e.pc + 32'd4);
                end
            end
            if (rst && redirect_valid) begin
                exp_q.delete();
                exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
        if (!rst) begin
            exp_q.delete();
            exp_fetch_pc = 32'h0;
        end
        rst_prev = rst;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog_timeout actual=%0t required=finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic wait_beats(input int n, input int max_cycles);
        for (int i = 0; i < max_cycles && beat_count < n; i++) step();
        chk("wait_beats", (beat_count >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic hold_reset(input int mode, input logic ready);
        rst      = 1'b0;
        ack_mode = mode;
        id_ready = ready;
        step();
        step();
        rst        = 1'b1;
        beat_count = 0;
    endtask

    initial begin
        // 1: reset state and first fetch
        ack_mode = 1;
        id_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_next_pc", id_next_pc, 32'h4);
        step();
        rst        = 1'b1;
        beat_count = 0;
        step();
        @(negedge clk);
        chk("first_mem_req", 32'(mem_req), 32'd1);
        chk("first_mem_addr", mem_addr, 32'h0);
`ifdef IF_BYPASS_EN
        chk("first_bypass_pc", id_pc, 32'h0);
`else
        chk("first_id_valid", 32'(id_valid), 32'd0);
        step();
        @(negedge clk);
        chk("t1_id_valid", 32'(id_valid), 32'd1);
        chk("t1_id_pc", id_pc, 32'h0);
        chk("t1_id_inst", id_inst, 32'hA5A5A5A5);
        chk("t1_id_next_pc", id_next_pc, 32'h4);
`endif
        repeat (6) step();

        // 2: fill to full, then one pop re-opens the request
        hold_reset(1, 1'b0);
        repeat (7) step();
        @(negedge clk);
        chk("full_beats", 32'(beat_count), 32'd4);
        chk("full_mem_req", 32'(mem_req), 32'd0);
        chk("full_mem_addr", mem_addr, 32'h10);
        chk("full_head_pc", id_pc, 32'h0);
        step();
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        @(negedge clk);
        chk("reopen_mem_req", 32'(mem_req), 32'd1);
        chk("reopen_mem_addr", mem_addr, 32'h10);
        step();
        @(negedge clk);
        chk("refill_beats", 32'(beat_count), 32'd5);
        chk("refill_mem_req", 32'(mem_req), 32'd0);

        // 3: redirect while the fetch at 8 is un-acked
        hold_reset(1, 1'b1);
        wait_beats(2, 20);
        ack_mode = 0;
        @(negedge clk);
        chk("pend_mem_addr", mem_addr, 32'h8);
        chk("pend_mem_req", 32'(mem_req), 32'd1);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_id_valid", 32'(id_valid), 32'd0);
        chk("redir_mem_addr", mem_addr, 32'h100);
        chk("redir_mem_req", 32'(mem_req), 32'd1);
        step();
        ack_mode = 1;
        repeat (6) step();

        // 4: redirect coincident with ack and pop while two entries are held
        hold_reset(1, 1'b0);
        wait_beats(2, 20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        id_ready       = 1'b1;
        @(negedge clk);
        chk("coin_two_held", 32'(id_valid), 32'd1);
        step();
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        @(negedge clk);
        chk("coin_mem_addr", mem_addr, 32'h200);
`ifndef IF_BYPASS_EN
        chk("coin_id_valid", 32'(id_valid), 32'd0);
`endif
        for (int i = 0; i < 10 && !id_valid; i++) begin
            step();
            @(negedge clk);
        end
        chk("coin_first_pc", id_pc, 32'h200);
        step();
        id_ready = 1'b1;
        repeat (4) step();

        // 5: random stall and random ack
        ack_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            step();
            id_ready = ($urandom_range(0, 1) == 1);
        end
        ack_mode = 0;
        id_ready = 1'b1;
        repeat (8) step();

        // 6: single ack into an empty FIFO
        rdata_xor = 32'h34010001;
        hold_reset(0, 1'b1);
        step();
        ack_mode = 1;
        @(negedge clk);
`ifdef IF_BYPASS_EN
        chk("byp_same_valid", 32'(id_valid), 32'd1);
        chk("byp_same_inst", id_inst, 32'h34010001);
        chk("byp_same_pc", id_pc, 32'h0);
`else
        chk("nobyp_same_valid", 32'(id_valid), 32'd0);
`endif
        step();
        ack_mode = 0;
        @(negedge clk);
`ifdef IF_BYPASS_EN
        chk("byp_after_valid", 32'(id_valid), 32'd0);
`else
        chk("nobyp_after_valid", 32'(id_valid), 32'd1);
        chk("nobyp_after_inst", id_inst, 32'h34010001);
        chk("nobyp_after_pc", id_pc, 32'h0);
`endif
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
